// File: rtl/regression_stream_ctrl.sv
// rtl/regression_stream_ctrl.sv - streams stored (X, Y) samples into the error checker and sums returned E
module regression_stream_ctrl #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_x,
    input  logic [WIDTH-1:0]      wr_y,
    input  logic [WIDTH-1:0]      b0_in,
    input  logic [WIDTH-1:0]      b1_in,
    input  logic                  start,
    input  logic [AW:0]           count,
    output logic [WIDTH-1:0]      X,
    output logic [WIDTH-1:0]      Y,
    output logic [WIDTH-1:0]      B0,
    output logic [WIDTH-1:0]      B1,
    output logic                  en2,
    output logic                  ld_er,
    input  logic [WIDTH-1:0]      E,
    output logic                  err_valid,
    output logic [WIDTH+AW-1:0]   sum_e,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_FLUSH0 = 3'd3;
    localparam logic [2:0] S_FLUSH1 = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       state;
    logic [AW-1:0]    idx;
    logic [AW:0]      n_reg;
    logic [AW:0]      n_clamped;
    logic             p1;
    logic             p2;
    logic             last_sample;
    logic [WIDTH-1:0] x_hold;
    logic [WIDTH-1:0] y_hold;
    logic [WIDTH-1:0] mem_x [DEPTH];
    logic [WIDTH-1:0] mem_y [DEPTH];

    assign n_clamped   = (count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count;
    assign last_sample = ({1'b0, idx} == n_reg - 1'b1);

    assign busy      = (state == S_CLEAR) || (state == S_STREAM) ||
                       (state == S_FLUSH0) || (state == S_FLUSH1);
    assign en2       = (state == S_STREAM) || (state == S_FLUSH0);
    assign ld_er     = (state == S_CLEAR);
    assign done      = (state == S_DONE);
    // p2 can be left set by the previous pass, so qualify it with the streaming states only
    assign err_valid = p2 && ((state == S_STREAM) || (state == S_FLUSH0) || (state == S_FLUSH1));

    // Outside STREAM the last presented sample is held (reset clears it to zero)
    assign X  = (state == S_STREAM) ? mem_x[idx] : x_hold;
    assign Y  = (state == S_STREAM) ? mem_y[idx] : y_hold;

    // Sample memory is deliberately not reset so a pass can be rerun after an abort
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem_x[wr_addr] <= wr_x;
            mem_y[wr_addr] <= wr_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            n_reg  <= '0;
            p1     <= 1'b0;
            p2     <= 1'b0;
            x_hold <= '0;
            y_hold <= '0;
            B0     <= '0;
            B1     <= '0;
            sum_e  <= '0;
        end else begin
            if (en2) begin
                p1 <= (state == S_STREAM);
                p2 <= p1;
            end
            if (err_valid) begin
                sum_e <= sum_e + {{AW{1'b0}}, E};
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (n_clamped != '0) begin
                            B0    <= b0_in;
                            B1    <= b1_in;
                            n_reg <= n_clamped;
                            state <= S_CLEAR;
                        end else begin
                            sum_e <= '0;
                            state <= S_DONE;
                        end
                    end
                end
                S_CLEAR: begin
                    sum_e <= '0;
                    idx   <= '0;
                    p1    <= 1'b0;
                    p2    <= 1'b0;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    idx    <= idx + 1'b1;
                    x_hold <= mem_x[idx];
                    y_hold <= mem_y[idx];
                    if (last_sample) begin
                        state <= S_FLUSH0;
                    end
                end
                S_FLUSH0: state <= S_FLUSH1;
                S_FLUSH1: state <= S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regression_stream_ctrl.sv
// tb/tb_regression_stream_ctrl.sv - randomized self-checking bench with checker model and pass-level reference
module tb_regression_stream_ctrl;

    localparam int W  = 20;
    localparam int D  = 16;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [W-1:0]    wr_x = '0;
    logic [W-1:0]    wr_y = '0;
    logic [W-1:0]    b0_in = '0;
    logic [W-1:0]    b1_in = '0;
    logic            start = 1'b0;
    logic [AW:0]     count = '0;
    logic [W-1:0]    X, Y, B0, B1;
    logic            en2, ld_er, err_valid, busy, done;
    logic [W-1:0]    E = '0;
    logic [W+AW-1:0] sum_e;

    logic [W-1:0]    sh_x [D];
    logic [W-1:0]    sh_y [D];
    logic [W-1:0]    chk_s1 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    regression_stream_ctrl #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .b0_in(b0_in), .b1_in(b1_in),
        .start(start), .count(count), .X(X), .Y(Y), .B0(B0), .B1(B1),
        .en2(en2), .ld_er(ld_er), .E(E), .err_valid(err_valid),
        .sum_e(sum_e), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Two-stage error checker: sample presented in cycle k shows on E in cycle k+2
    always @(posedge clk) begin
        if (ld_er) begin
            chk_s1 <= '0;
            E      <= '0;
        end else if (en2) begin
            chk_s1 <= Y * (B0 + X * B1);
            E      <= chk_s1;
        end
    end

    function automatic logic [W-1:0] e_of(input logic [W-1:0] x, y, b0, b1);
        return y * (b0 + x * b1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_slot(input int a, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_x = x; wr_y = y;
        sh_x[a] = x; sh_y[a] = y;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run_pass(input logic [W-1:0] b0, input logic [W-1:0] b1, input int cnt,
                            input bit inject, input bit wr_with_start);
        int n;
        int cycles, nld, nbusy, nen2, nerr;
        int a;
        logic [W-1:0]    e;
        logic [W+AW-1:0] exp_sum;
        logic [W-1:0]    q[$];
        n = (cnt > D) ? D : cnt;
        @(negedge clk);
        if (wr_with_start) begin
            a = $urandom_range(0, D-1);
            wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_x = W'($urandom); wr_y = W'($urandom);
            sh_x[a] = wr_x; sh_y[a] = wr_y;
        end
        b0_in = b0; b1_in = b1; count = cnt[AW:0]; start = 1'b1;
        exp_sum = '0;
        q = {};
        for (int k = 0; k < n; k++) begin
            e = e_of(sh_x[k], sh_y[k], b0, b1);
            q.push_back(e);
            exp_sum = exp_sum + {{AW{1'b0}}, e};
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        cycles = 1; nld = 0; nbusy = 0; nen2 = 0; nerr = 0;
        forever begin
            if (ld_er) nld++;
            if (busy)  nbusy++;
            if (en2)   nen2++;
            if (err_valid) begin
                nerr++;
                if (q.size() > 0) check("e_seq", E, q.pop_front());
                else check("err_valid_count", nerr, n);
            end
            if (inject && cycles == 3) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 1; wr_x = 9; wr_y = 9;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (done || cycles >= 100) break;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0; wr_en = 1'b0;
        check("done_latency", cycles, (n == 0) ? 1 : n + 4);
        check("sum_e", sum_e, exp_sum);
        check("ld_er_cycles", nld, (n == 0) ? 0 : 1);
        check("busy_cycles", nbusy, (n == 0) ? 0 : n + 3);
        check("en2_cycles", nen2, (n == 0) ? 0 : n + 1);
        check("err_valid_cycles", nerr, n);
        if (n > 0) begin
            check("b0_latched", B0, b0);
            check("b1_latched", B1, b1);
        end
        @(negedge clk);
        check("done_pulse", done, 0);
        check("sum_e_hold", sum_e, exp_sum);
    endtask

    task automatic check_reset_outputs();
        check("rst_x", X, 0);
        check("rst_y", Y, 0);
        check("rst_b0", B0, 0);
        check("rst_b1", B1, 0);
        check("rst_sum_e", sum_e, 0);
        check("rst_en2", en2, 0);
        check("rst_ld_er", ld_er, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        for (int i = 0; i < D; i++) write_slot(i, W'($urandom), W'($urandom));

        // single sample
        write_slot(0, 1, 4);
        run_pass(3, 2, 1, 0, 0);
        check("sum_n1", sum_e, 20);

        // three samples
        write_slot(1, 5, 1);
        write_slot(2, 0, 7);
        run_pass(3, 2, 3, 0, 0);
        check("sum_n3", sum_e, 54);

        // empty pass
        run_pass(5, 5, 0, 0, 0);

        // start and write while busy are ignored, then the write lands afterwards
        run_pass(3, 2, 3, 1, 0);
        check("sum_inject", sum_e, 54);
        write_slot(1, 9, 9);
        run_pass(3, 2, 3, 0, 0);
        check("sum_rerun", sum_e, 230);

        // reset during STREAM, then restart from retained memory
        write_slot(1, 5, 1);
        @(negedge clk);
        b0_in = 3; b1_in = 2; count = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs();
        run_pass(3, 2, 3, 0, 0);
        check("sum_after_reset", sum_e, 54);

        // clamp to DEPTH
        for (int i = 0; i < D; i++) write_slot(i, 20'hFFFFF, 20'hFFFFF);
        run_pass(0, 1, 20, 0, 0);
        check("sum_clamp", sum_e, 16);

        // randomized passes
        for (int it = 0; it < 10; it++) begin
            for (int j = 0; j < 4; j++)
                write_slot($urandom_range(0, D-1), W'($urandom), W'($urandom));
            run_pass(W'($urandom), W'($urandom), $urandom_range(0, 31), 0, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regression_stream_ctrl.md
Name: regression_stream_ctrl

Overview:
- Initiator side of the regression error-check interface.
- Holds a small sample memory of (X, Y) pairs, latches coefficients B0/B1, and streams each sample into the error checker with the en2/ld_er controls.
- Collects the returned E values in pipeline order and produces their running sum and a done pulse.
- Sits between the training/coefficient logic, which writes samples and issues start, and the error checker, which consumes X, Y, B0, B1 and returns E.

Parameters:
WIDTH, 20, data width of X, Y, B0, B1, E
DEPTH, 16, number of sample slots
AW, 4, address width, log2(DEPTH)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  sample write strobe; ignored while busy
wr_addr  in  AW  sample slot to write
wr_x  in  WIDTH  X value to store
wr_y  in  WIDTH  Y value to store
b0_in  in  WIDTH  B0 coefficient, latched on accepted start
b1_in  in  WIDTH  B1 coefficient, latched on accepted start
start  in  1  begin a pass; ignored while busy
count  in  AW+1  samples in the pass; 0..DEPTH, values above DEPTH clamp to DEPTH
X  out  WIDTH  sample X to checker
Y  out  WIDTH  sample Y to checker
B0  out  WIDTH  latched B0 to checker
B1  out  WIDTH  latched B1 to checker
en2  out  1  checker register enable
ld_er  out  1  checker E-register clear
E  in  WIDTH  checker result
err_valid  out  1  E currently holds a valid sample result
sum_e  out  WIDTH+AW  accumulated E, wraps mod 2^(WIDTH+AW)
busy  out  1  pass in progress
done  out  1  one-cycle pass-complete pulse

Behaviour:
- Reset: synchronous, active-high; reset is synchronous and active-high.
  - On reset: state IDLE; X, Y, B0, B1, sum_e all 0; en2, ld_er, err_valid, busy, done all 0.
  - Sample memory is not reset; its contents are retained.
  - Reset mid-pass aborts immediately to these values.
- Memory write: when wr_en=1 and busy=0, mem[wr_addr] <= {wr_x, wr_y} at the edge.
- IDLE: busy=0.
  - start=1 with clamped count n>0: latch B0, B1 and n; go to CLEAR.
  - start=1 with n=0: go to DONE; sum_e cleared to 0.
- CLEAR (1 cycle): busy=1, ld_er=1, en2=0.
  - sum_e <= 0, idx <= 0, pipeline flags p1, p2 <= 0.
  - Go to STREAM.
- STREAM (n cycles): X/Y driven combinationally from mem[idx]; en2=1.
  - idx increments each cycle.
  - Leave to FLUSH0 after the cycle with idx=n-1.
- FLUSH0 (1 cycle): en2=1; X/Y hold the last sample.
- FLUSH1 (1 cycle): en2=0; then go to DONE.
- DONE (1 cycle): done=1, busy=0; then go to IDLE.
- B0/B1 outputs hold their latched values until the next accepted start.
- Valid tracking, at every edge where en2=1:
  - p1 <= (state==STREAM); p2 <= p1.
  - err_valid = p2 while busy, i.e. in STREAM, FLUSH0 and FLUSH1.
- Checker latency: sample k is presented in pass cycle k (cycle 0 is the first STREAM cycle). E = Y*(B0+X*B1) mod 2^WIDTH for that sample is visible in cycle k+2.
- Accumulation: when err_valid=1, sum_e <= sum_e + zero-extended E. Exactly n additions occur per pass.
- sum_e is final in the DONE cycle and holds until the next CLEAR.
- Total pass length is n+4 cycles from the start edge to the done pulse.
- Boundaries:
  - n=1: err_valid is asserted only in FLUSH1.
  - n=DEPTH: idx wraps after the last sample, but the wrapped value is unused.
  - start and wr_en while busy have no effect.
  - wr_en together with start in IDLE: the write takes effect; the pass then reads the new data.

Test Plan:
1. Bench loads mem[0]=(X=1,Y=4), then start with B0=3, B1=2, count=1 -> ld_er pulses for one cycle; one err_valid cycle with E=20; done after 5 cycles with sum_e=20.
2. Bench loads slots 0..2 with (1,4), (5,1), (0,7), then start with B0=3, B1=2, count=3 -> E sequence 20, 13, 21 on err_valid; sum_e=54; busy for 6 cycles.
3. start with count=0 -> done on the next cycle; sum_e=0; en2 and ld_er never asserted.
4. count=20 with all 16 slots = (X=0xFFFFF, Y=0xFFFFF), B0=0, B1=1 -> clamped to 16 samples.
   - Each E=1, because (2^20-1)^2 mod 2^20 = 1.
   - sum_e=16.
5. Reset asserted during STREAM of scenario 2 -> next cycle state IDLE, all outputs 0; an immediate restart yields sum_e=54 again, since memory is retained.
6. During scenario 2, bench asserts start and wr_en to slot 1 with (9,9) -> both ignored; sum_e=54. After done, the write is accepted and a rerun gives sum_e = 20 + 9*(3+18) + 21 = 230.
